// File: rtl/field_sel_pkg.sv
// Shared constants, word layout and FSM state type for the 16-bit field-select datapath.
package field_sel_pkg;

    localparam int FIELD_W    = 3;
    localparam int NUM_FIELDS = 4;
    localparam int WORD_W     = 16;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 2;
    localparam int FILL_W     = $clog2(NUM_FIELDS);

    // Word layout: select code at the bottom, fields above it, tag on top.
    localparam int SEL_LSB    = 0;
    localparam int FIELD_LSB0 = SEL_LSB + SEL_W;
    localparam int TAG_LSB    = FIELD_LSB0 + NUM_FIELDS * FIELD_W;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    function automatic int field_lsb(input int idx);
        return FIELD_LSB0 + idx * FIELD_W;
    endfunction

endpackage

// File: rtl/field_word_out_reg.sv
// Valid/ready output holding register: i_load captures a word, i_accept retires it.
module field_word_out_reg
    import field_sel_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_accept,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid
);

    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end else if (i_accept) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; next values come from always_comb.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/field_word_packer.sv
// Packs four 3-bit fields into a tagged 16-bit word behind a valid/ready output register.
// Build option FIELD_WORD_PACKER_PARITY_EN puts even parity in bit 15 and counter bit 0 in bit 14.
module field_word_packer
    import field_sel_pkg::*;
#(
    parameter logic [SEL_W-1:0] SEL_START      = 2'd0,
    parameter logic [SEL_W-1:0] SEL_STEP       = 2'd1,
    parameter bit               FLUSH_KEEP_SEL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_field,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_flush,
    output logic [15:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [1:0]  o_fill
);

    state_e                                state_q, state_d;
    logic [FILL_W-1:0]                     fill_q, fill_d;
    logic [NUM_FIELDS-2:0][FIELD_W-1:0]    slot_q, slot_d;
    logic [SEL_W-1:0]                      sel_q, sel_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [WORD_W-1:0]                     word;
    logic                                  load;
    logic                                  accept;

    // The fourth field goes straight from i_field into the word; only three slots are stored.
    always_comb begin
        word = '0;
        word[SEL_LSB +: SEL_W] = sel_q;
        for (int i = 0; i < NUM_FIELDS - 1; i++) begin
            word[field_lsb(i) +: FIELD_W] = slot_q[i];
        end
        word[field_lsb(NUM_FIELDS - 1) +: FIELD_W] = i_field;
`ifdef FIELD_WORD_PACKER_PARITY_EN
        word[TAG_LSB]    = cnt_q[0];
        word[WORD_W - 1] = ^word[WORD_W-2:0];
`else
        word[TAG_LSB +: CNT_W] = cnt_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        slot_d  = slot_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            FILL: begin
                if (i_flush) begin
                    fill_d = '0;
                    if (!FLUSH_KEEP_SEL) begin
                        sel_d = SEL_START;
                    end
                end else if (i_valid) begin
                    if (fill_q == FILL_W'(NUM_FIELDS - 1)) begin
                        load    = 1'b1;
                        fill_d  = '0;
                        state_d = FULL;
                    end else begin
                        for (int i = 0; i < NUM_FIELDS - 1; i++) begin
                            if (fill_q == FILL_W'(i)) begin
                                slot_d[i] = i_field;
                            end
                        end
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (i_ready) begin
                    accept  = 1'b1;
                    state_d = FILL;
                    sel_d   = sel_q + SEL_STEP;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            sel_q   <= SEL_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: slot storage is left out of reset; unwritten slots are never emitted.
    always_ff @(posedge i_clk) begin
        slot_q <= slot_d;
    end

    field_word_out_reg u_out_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (load),
        .i_data   (word),
        .i_accept (accept),
        .o_data   (o_data),
        .o_valid  (o_valid)
    );

    assign o_ready = (state_q == FILL);
    assign o_fill  = fill_q;

endmodule

// File: tb/tb_field_word_packer.sv
// Self-checking bench for field_word_packer: directed literal checks plus randomized traffic
// compared every cycle against a queue/arithmetic model of the packer.
module tb_field_word_packer;

    localparam logic [1:0] SEL_START      = 2'd0;
    localparam logic [1:0] SEL_STEP       = 2'd1;
    localparam bit         FLUSH_KEEP_SEL = 1'b0;

    logic        i_clk;
    logic        i_rst;
    logic [2:0]  i_field;
    logic        i_valid;
    logic        o_ready;
    logic        i_flush;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic [1:0]  o_fill;

    int n_checks = 0;
    int n_fail   = 0;

    field_word_packer #(
        .SEL_START      (SEL_START),
        .SEL_STEP       (SEL_STEP),
        .FLUSH_KEEP_SEL (FLUSH_KEEP_SEL)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_field (i_field),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_flush (i_flush),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_fill  (o_fill)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fields collected in an array, word built by arithmetic.
    int m_f[4];
    int m_fill = 0;
    int m_sel  = int'(SEL_START);
    int m_cnt  = 0;
    int m_data = 0;
    bit m_full = 1'b0;

    function automatic int make_word();
        int w;
        w = m_sel + (m_f[0] << 2) + (m_f[1] << 5) + (m_f[2] << 8) + (m_f[3] << 11);
`ifdef FIELD_WORD_PACKER_PARITY_EN
        w += (m_cnt % 2) << 14;
        w += ($countones(w) % 2) << 15;
`else
        w += m_cnt << 14;
`endif
        return w;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst === 1'b1) begin
            m_full = 1'b0;
            m_fill = 0;
            m_data = 0;
            m_sel  = int'(SEL_START);
            m_cnt  = 0;
        end else if (m_full) begin
            if (i_ready === 1'b1) begin
                m_full = 1'b0;
                m_sel  = (m_sel + int'(SEL_STEP)) % 4;
                m_cnt  = (m_cnt + 1) % 4;
            end
        end else if (i_flush === 1'b1) begin
            m_fill = 0;
            if (!FLUSH_KEEP_SEL) m_sel = int'(SEL_START);
        end else if (i_valid === 1'b1) begin
            m_f[m_fill] = int'(i_field);
            if (m_fill == 3) begin
                m_data = make_word();
                m_full = 1'b1;
                m_fill = 0;
            end else begin
                m_fill++;
            end
        end
    end

    always @(negedge i_clk) begin
        check("valid", 32'(o_valid), 32'(m_full));
        check("ready", 32'(o_ready), 32'(!m_full));
        check("fill",  32'(o_fill),  32'(m_fill));
        check("data",  32'(o_data),  32'(m_data));
    end

    // Drives one cycle of inputs and returns at the following negedge.
    task automatic tick(input bit v, input int f, input bit fl, input bit rd, input bit rs);
        i_valid = v;
        i_field = 3'(f);
        i_flush = fl;
        i_ready = rd;
        i_rst   = rs;
        @(negedge i_clk);
    endtask

    initial begin
        logic [15:0] held;
        int          r;

        i_valid = 1'b0;
        i_field = 3'd0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_rst   = 1'b1;
        @(negedge i_clk);

        // Reset state.
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_data",  32'(o_data),  32'h0000);
        check("rst_fill",  32'(o_fill),  32'd0);

        // First word: fields 1,2,3,4.
        for (int k = 1; k <= 4; k++) tick(1'b1, k, 1'b0, 1'b1, 1'b0);
        check("w1_valid", 32'(o_valid), 32'd1);
`ifdef FIELD_WORD_PACKER_PARITY_EN
        check("w1_data", 32'(o_data), 32'hA344);
`else
        check("w1_data", 32'(o_data), 32'h2344);
`endif
        tick(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("w1_drop", 32'(o_valid), 32'd0);

        // Three back-to-back words after reset: select and tag step 0,1,2.
        tick(1'b0, 0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) tick(1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b0);
            check("b2b_sel", 32'(o_data[1:0]), 32'(k));
`ifdef FIELD_WORD_PACKER_PARITY_EN
            check("b2b_tag", 32'(o_data[14]), 32'(k % 2));
`else
            check("b2b_tag", 32'(o_data[15:14]), 32'(k));
`endif
            tick(1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b1, 1'b0);
        end

        // Flush after two fields: fill clears, select reloads, no stale data.
        tick(1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 2, 1'b0, 1'b0, 1'b0);
        check("pre_flush_fill", 32'(o_fill), 32'd2);
        tick(1'b1, 3, 1'b1, 1'b0, 1'b0);
        check("flush_fill", 32'(o_fill), 32'd0);
        tick(1'b1, 5, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 6, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 7, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("flush_word", 32'(o_data[13:0]), 32'h07D4);
        tick(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Backpressure: word held for six cycles while fields keep arriving.
        for (int j = 0; j < 4; j++) tick(1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
        held = o_data;
        for (int j = 0; j < 6; j++) begin
            tick(1'b1, int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
            check("bp_ready", 32'(o_ready), 32'd0);
        end
        check("bp_stable", 32'(o_data), 32'(held));
        tick(1'b1, 1, 1'b0, 1'b1, 1'b0);
        check("bp_drain_valid", 32'(o_valid), 32'd0);
        check("bp_drain_fill",  32'(o_fill),  32'd0);

        // Reset while a word is waiting.
        for (int j = 0; j < 4; j++) tick(1'b1, 4, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4, 1'b0, 1'b1, 1'b1);
        check("rstfull_valid", 32'(o_valid), 32'd0);
        check("rstfull_ready", 32'(o_ready), 32'd1);
        check("rstfull_data",  32'(o_data),  32'h0000);

        // Parity pattern 7,0,0,0 with select 0 and counter 0.
        tick(1'b1, 7, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) tick(1'b1, 0, 1'b0, 1'b0, 1'b0);
`ifdef FIELD_WORD_PACKER_PARITY_EN
        check("par_word", 32'(o_data), 32'h801C);
        check("par_even", 32'($countones(o_data) % 2), 32'd0);
`else
        check("par_word", 32'(o_data), 32'h001C);
        check("par_bit15", 32'(o_data[15]), 32'd0);
`endif
        tick(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic; flush only offered while the packer is filling.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            tick(r < 70,
                 int'($urandom_range(0, 7)),
                 !m_full && ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/field_word_packer.md
Name: field_word_packer

Overview:
- Upstream stage of the 16-bit field-select datapath.
- Collects four 3-bit fields, arriving one per accepted transfer, into one 16-bit word, and tags the word with a 2-bit select code.
- Presents the word through a valid/ready output register to the downstream field selector, which registers the field indexed by bits [1:0].
- Select code rotates per emitted word, so the downstream stage returns field0, field1, field2, field3 in turn.

Parameters:
- SEL_START, 2'd0, select code placed in word bits [1:0] for the first word after reset or flush.
- SEL_STEP, 2'd1, added modulo 4 to the select code after each word is accepted downstream.
- FLUSH_KEEP_SEL, 1'b0, 1 = i_flush leaves the select code unchanged; 0 = i_flush reloads SEL_START.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_field  input  3  field data
- i_valid  input  1  i_field valid
- o_ready  output  1  packer can accept a field this cycle
- i_flush  input  1  discard partial word; synchronous
- o_data  output  16  packed word
- o_valid  output  1  o_data valid
- i_ready  input  1  downstream accepts o_data
- o_fill  output  2  fields held in the current partial word (0..3)

Behaviour:
- Reset state, all registered:
  - FSM = FILL; o_valid = 0; o_ready = 1; o_data = 16'h0000; o_fill = 0.
  - Select register = SEL_START; word counter = 0.
  - Reset overrides all other inputs, mid-word or mid-handshake.
- Word layout:
  - [1:0] = select code; [4:2] = field0 (first accepted); [7:5] = field1; [10:8] = field2; [13:11] = field3.
  - [15:14] = word counter bits [1:0]. The word counter is a free-running 2-bit count of emitted words that wraps 3 -> 0.
- FSM state FILL:
  - o_ready = 1 and o_valid = 0.
  - A transfer occurs when i_valid = 1. The field is written to slot o_fill, then o_fill increments.
  - On the 4th transfer (o_fill = 3):
    - o_data is loaded with the complete word and the current select code.
    - o_valid = 1 and o_fill = 0 on the next cycle; FSM goes to FULL.
  - Latency: o_valid rises 1 cycle after the 4th field is accepted.
- FSM state FULL:
  - o_ready = 0 and o_valid = 1. o_data is held stable while o_valid = 1 and i_ready = 0.
  - When i_ready = 1:
    - Next cycle: o_valid = 0 and FSM = FILL.
    - Select register += SEL_STEP (mod 4); word counter += 1 (mod 4).
  - i_valid is ignored in FULL.
  - Sustained throughput is 4 fields per 5 cycles.
- o_ready and o_valid are pure functions of FSM state. There is no combinational path from i_ready to o_ready.
- i_flush:
  - In FILL: o_fill goes to 0, partial data is discarded, and any same-cycle i_valid transfer is dropped.
  - In FULL: no effect; the completed word still drains.
  - Select register reloads SEL_START unless FLUSH_KEEP_SEL = 1. The word counter is unaffected.
- Field slots not yet written in a partial word are don't-care internally. o_data only changes on word completion.

Optional Feature:
- Macro: FIELD_WORD_PACKER_PARITY_EN.
- Defined:
  - o_data[15] = even parity over o_data[14:0], i.e. XOR of bits [14:0], so the full word has even parity.
  - o_data[14] = word counter bit 0.
- Undefined: [15:14] = word counter bits [1:0] as above.

Decomposition:
- Shared package field_sel_pkg:
  - FIELD_W = 3, NUM_FIELDS = 4, WORD_W = 16, SEL_W = 2.
  - Bit-position constants for each field slot and the select/tag positions.
  - FSM state enum {FILL, FULL}.
- One natural sub-module: field_word_out_reg, the 16-bit valid/ready output holding register with load/accept strobes. The FSM and field slots stay in the top module.

Test Plan:
- Reset, then stream fields 3'd1, 3'd2, 3'd3, 3'd4 with i_valid = 1 and i_ready = 1 → one cycle after the 4th field, o_valid = 1 and o_data = 16'h0000 | (4<<11)|(3<<8)|(2<<5)|(1<<2)|0 = 16'h2344; drops next cycle.
- Three back-to-back words with i_ready held 1 → [1:0] = 0, 1, 2 and [15:14] = 0, 1, 2.
- Word complete with i_ready = 0 for 6 cycles while i_valid = 1 → o_data stable, o_ready = 0, extra fields not absorbed. i_ready = 1 → accepted, FILL resumes with o_fill = 0.
- Two fields accepted, then i_flush with i_valid = 1 → o_fill = 0; the next 4 fields form a word with no stale data, and the select code = SEL_START.
- i_rst asserted while FULL with o_valid = 1 → next cycle o_valid = 0, o_ready = 1, o_data = 16'h0000, select = SEL_START.
- With FIELD_WORD_PACKER_PARITY_EN, fields 7, 0, 0, 0 → o_data[15] = 1 and total popcount even; without the macro, o_data[15] = counter bit 1.
